// File: rtl/mbus_write_arbiter_if.sv
// Bus bundle between the frame-write channels, the write arbiter and the DDR write controller.
// The master modport is the arbiter's view; the slave modport is the channels/controller view.
interface mbus_write_arbiter_if #(
    parameter int CH_NUM          = 4,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH      = 128
);
    logic [CH_NUM-1:0]                 i_ch_wrq;
    logic [CH_NUM-1:0]                 i_ch_wready;
    logic [CH_NUM*CTRL_ADDR_WIDTH-1:0] i_ch_waddr;
    logic [CH_NUM*DATA_WIDTH-1:0]      i_ch_wdata;
    logic [CH_NUM-1:0]                 o_ch_wsel;
    logic [CH_NUM-1:0]                 o_ch_wdata_rq;
    logic [CH_NUM-1:0]                 o_ch_wbusy;
    logic                              o_ddr_wrq;
    logic [CTRL_ADDR_WIDTH-1:0]        o_ddr_waddr;
    logic [DATA_WIDTH-1:0]             o_ddr_wdata;
    logic                              i_ddr_wdata_rq;
    logic                              i_ddr_wbusy;
    logic                              o_timeout;

    modport master (
        input  i_ch_wrq, i_ch_wready, i_ch_waddr, i_ch_wdata, i_ddr_wdata_rq, i_ddr_wbusy,
        output o_ch_wsel, o_ch_wdata_rq, o_ch_wbusy, o_ddr_wrq, o_ddr_waddr, o_ddr_wdata, o_timeout
    );

    modport slave (
        output i_ch_wrq, i_ch_wready, i_ch_waddr, i_ch_wdata, i_ddr_wdata_rq, i_ddr_wbusy,
        input  o_ch_wsel, o_ch_wdata_rq, o_ch_wbusy, o_ddr_wrq, o_ddr_waddr, o_ddr_wdata, o_timeout
    );
endinterface

// File: rtl/mbus_write_arbiter.sv
// Round-robin arbiter sharing one DDR write-controller port among CH_NUM frame-write channels,
// with a request watchdog that frees the bus if the controller never accepts a burst.
module mbus_write_arbiter #(
    parameter int MEM_DQ_WIDTH    = 16,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int BURST_LENGTH    = 8,
    parameter int CH_NUM          = 4,
    parameter int TIMEOUT_CYC     = 1023
) (
    input  logic                 i_axi_aclk,
    input  logic                 i_rst,
    mbus_write_arbiter_if.master bus
);
    localparam int W   = MEM_DQ_WIDTH * BURST_LENGTH;
    localparam int IDW = $clog2(CH_NUM);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, GRANT, CHECK, REQ, BUSY, RELEASE} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [IDW-1:0]             gnt_id;
    logic [IDW-1:0]             last;
    logic [IDW-1:0]             pick;
    logic [IDW:0]               rr_idx;
    logic                       rr_found;
    logic                       gnt_valid;
    logic                       fake_busy;
    logic [TW-1:0]              timer;
    logic [1:0]                 rel_cnt;
    logic [CTRL_ADDR_WIDTH-1:0] waddr_q;
    logic [CH_NUM-1:0]          eligible;
    logic                       any_eligible;
    logic                       timeout_hit;
    logic                       rel_done;

    assign eligible     = bus.i_ch_wrq & bus.i_ch_wready;
    assign any_eligible = |eligible;
    assign timeout_hit  = (state == REQ) && !bus.i_ddr_wbusy && (timer == TW'(TIMEOUT_CYC));
    assign rel_done     = (state == RELEASE) && (rel_cnt == 2'd2);

    // Search starts one past the previous grantee and wraps, so every channel gets a turn.
    always_comb begin
        pick     = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            rr_idx = {1'b0, last} + (IDW+1)'(i);
            if (rr_idx >= (IDW+1)'(CH_NUM)) begin
                rr_idx = rr_idx - (IDW+1)'(CH_NUM);
            end
            if (!rr_found && eligible[rr_idx[IDW-1:0]]) begin
                pick     = rr_idx[IDW-1:0];
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_axi_aclk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_eligible) state_nxt = GRANT;
            GRANT:   state_nxt = CHECK;
            // A channel that restarted its frame drops ready; release without touching DDR.
            CHECK:   state_nxt = bus.i_ch_wready[gnt_id] ? REQ : RELEASE;
            REQ: begin
                if (bus.i_ddr_wbusy) begin
                    state_nxt = BUSY;
                end else if (timeout_hit) begin
                    state_nxt = RELEASE;
                end
            end
            BUSY:    if (!bus.i_ddr_wbusy) state_nxt = RELEASE;
            RELEASE: if (rel_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_axi_aclk or posedge i_rst) begin
        if (i_rst) begin
            gnt_id    <= '0;
            last      <= IDW'(CH_NUM - 1);
            gnt_valid <= 1'b0;
            fake_busy <= 1'b0;
            timer     <= '0;
            rel_cnt   <= '0;
            waddr_q   <= '0;
        end else begin
            fake_busy <= timeout_hit;
            timer     <= (state == REQ) ? timer + TW'(1) : '0;
            rel_cnt   <= (state == RELEASE) ? rel_cnt + 2'd1 : 2'd0;
            if (state == IDLE && any_eligible) begin
                gnt_id    <= pick;
                gnt_valid <= 1'b1;
                waddr_q   <= bus.i_ch_waddr[int'(pick)*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
            end
            // Three RELEASE cycles let the channel's busy synchronizer see the falling edge.
            if (rel_done) begin
                last      <= gnt_id;
                gnt_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.o_ch_wsel     = '0;
        bus.o_ch_wdata_rq = '0;
        bus.o_ch_wbusy    = '0;
        bus.o_ddr_wdata   = '0;
        bus.o_ddr_wrq     = (state == REQ);
        bus.o_timeout     = timeout_hit;
        bus.o_ddr_waddr   = waddr_q;
        if (gnt_valid) begin
            bus.o_ch_wdata_rq[gnt_id] = bus.i_ddr_wdata_rq;
            bus.o_ch_wbusy[gnt_id]    = bus.i_ddr_wbusy | fake_busy;
            bus.o_ddr_wdata           = bus.i_ch_wdata[int'(gnt_id)*W +: W];
        end
        if (state == GRANT) begin
            bus.o_ch_wsel[gnt_id] = 1'b1;
        end
    end
endmodule

// File: tb/tb_mbus_write_arbiter.sv
// Bench for mbus_write_arbiter: directed scenarios plus random traffic, all outputs compared
// every cycle against a grant-timeline model of the arbiter.
module tb_mbus_write_arbiter;
    localparam int CH = 4;
    localparam int A  = 28;
    localparam int W  = 128;
    localparam int TO = 15;

    logic aclk;
    logic rst;

    mbus_write_arbiter_if #(.CH_NUM(CH), .CTRL_ADDR_WIDTH(A), .DATA_WIDTH(W)) bus ();

    mbus_write_arbiter #(
        .MEM_DQ_WIDTH(16), .CTRL_ADDR_WIDTH(A), .BURST_LENGTH(8), .CH_NUM(CH), .TIMEOUT_CYC(TO)
    ) dut (
        .i_axi_aclk(aclk),
        .i_rst(rst),
        .bus(bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] wrq, input logic [CH-1:0] wready);
        bus.i_ch_wrq    = wrq;
        bus.i_ch_wready = wready;
    endtask

    // Controller stand-in: accepts a request after a short delay, then holds busy for a burst.
    int busy_len   = 4;
    int acc_max    = 0;
    bit ctrl_never = 1'b0;
    bit rand_mode  = 1'b0;
    int busy_left  = 0;
    int wait_cnt   = 0;
    int acc_delay  = 0;

    initial begin
        bus.i_ddr_wbusy    = 1'b0;
        bus.i_ddr_wdata_rq = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            bus.i_ddr_wdata_rq = 1'($urandom_range(0, 1));
            if (rst) begin
                bus.i_ddr_wbusy = 1'b0;
                busy_left       = 0;
                wait_cnt        = 0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) bus.i_ddr_wbusy = 1'b0;
            end else if (bus.o_ddr_wrq && !ctrl_never) begin
                if (wait_cnt >= acc_delay) begin
                    bus.i_ddr_wbusy = 1'b1;
                    busy_left       = rand_mode ? int'($urandom_range(1, 6)) : busy_len;
                    wait_cnt        = 0;
                    acc_delay       = int'($urandom_range(0, acc_max));
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Model: a grant is a timeline indexed by age (0 = select cycle, 1 = ready re-check,
    // 2.. = request), ending three cycles after the release point.
    int             m_owner = -1;
    int             m_last  = CH - 1;
    int             m_age   = 0;
    int             m_rel_at = -1;
    bit             m_timed_out = 1'b0;
    bit             m_busy_phase = 1'b0;
    bit             m_req_on;
    bit             m_fake;
    bit             m_found;
    int             m_pick;
    logic [A-1:0]   m_addr = '0;
    logic [CH-1:0]  m_elig;
    logic [CH-1:0]  e_sel, e_rq, e_busy;
    logic           e_wrq, e_to;
    logic [W-1:0]   e_wdata;

    always @(negedge aclk) begin
        e_sel = '0; e_rq = '0; e_busy = '0; e_wrq = 1'b0; e_to = 1'b0; e_wdata = '0;
        m_req_on = 1'b0;
        m_fake   = 1'b0;
        if (rst) begin
            m_owner = -1; m_last = CH - 1; m_age = 0; m_rel_at = -1;
            m_timed_out = 1'b0; m_busy_phase = 1'b0; m_addr = '0;
        end else if (m_owner >= 0) begin
            m_req_on = (m_age >= 2) && (m_rel_at < 0) && !m_busy_phase;
            m_fake   = m_timed_out && (m_age == m_rel_at);
            if (m_age == 0) e_sel[m_owner] = 1'b1;
            e_wrq           = m_req_on;
            e_to            = m_req_on && (m_age == 2 + TO) && !bus.i_ddr_wbusy;
            e_rq[m_owner]   = bus.i_ddr_wdata_rq;
            e_busy[m_owner] = bus.i_ddr_wbusy | m_fake;
            e_wdata         = bus.i_ch_wdata[m_owner*W +: W];
        end
        checkOutput("wsel",    W'(bus.o_ch_wsel),     W'(e_sel));
        checkOutput("wdata_rq", W'(bus.o_ch_wdata_rq), W'(e_rq));
        checkOutput("wbusy",   W'(bus.o_ch_wbusy),    W'(e_busy));
        checkOutput("ddr_wrq", W'(bus.o_ddr_wrq),     W'(e_wrq));
        checkOutput("timeout", W'(bus.o_timeout),     W'(e_to));
        checkOutput("ddr_waddr", W'(bus.o_ddr_waddr), W'(m_addr));
        checkOutput("ddr_wdata", bus.o_ddr_wdata,     e_wdata);
        if (!rst) begin
            if (m_owner < 0) begin
                m_elig  = bus.i_ch_wrq & bus.i_ch_wready;
                m_found = 1'b0;
                m_pick  = 0;
                for (int i = 1; i <= CH; i++) begin
                    if (!m_found && m_elig[(m_last + i) % CH]) begin
                        m_pick  = (m_last + i) % CH;
                        m_found = 1'b1;
                    end
                end
                if (m_found) begin
                    m_owner = m_pick; m_age = 0; m_rel_at = -1;
                    m_timed_out = 1'b0; m_busy_phase = 1'b0;
                    m_addr = bus.i_ch_waddr[m_pick*A +: A];
                end
            end else begin
                if (m_age == 1 && !bus.i_ch_wready[m_owner]) begin
                    m_rel_at = 2;
                end else if (m_req_on) begin
                    if (bus.i_ddr_wbusy) begin
                        m_busy_phase = 1'b1;
                    end else if (m_age == 2 + TO) begin
                        m_timed_out = 1'b1;
                        m_rel_at    = m_age + 1;
                    end
                end else if (m_busy_phase && m_rel_at < 0 && !bus.i_ddr_wbusy) begin
                    m_rel_at = m_age + 1;
                end
                if (m_rel_at >= 0 && m_age == m_rel_at + 2) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    task automatic waitSel(input int budget, output int id, output logic [CH-1:0] sel);
        id  = -1;
        sel = '0;
        for (int c = 0; c < budget && id < 0; c++) begin
            @(negedge aclk);
            if (bus.o_ch_wsel != '0) begin
                sel = bus.o_ch_wsel;
                for (int k = 0; k < CH; k++) if (bus.o_ch_wsel[k]) id = k;
            end
        end
        if (id < 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL wait_sel: no grant within %0d cycles", budget);
        end
    endtask

    task automatic doReset();
        @(posedge aclk); #1;
        applyStimulus('0, '0);
        rst = 1'b1;
        repeat (2) @(posedge aclk);
        #1 rst = 1'b0;
    endtask

    int             gid;
    logic [CH-1:0]  gsel;
    int             cnt_a, cnt_b, cnt_c;
    bit             flag;

    initial begin
        rst = 1'b1;
        applyStimulus('0, '0);
        bus.i_ch_waddr = {28'h0000300, 28'h0000200, 28'h0000080, 28'h0000000};
        bus.i_ch_wdata = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
        @(negedge aclk);
        checkOutput("reset_wsel",  W'(bus.o_ch_wsel),   W'(4'b0000));
        checkOutput("reset_waddr", W'(bus.o_ddr_waddr), W'(28'h0));
        repeat (2) @(posedge aclk);
        #1 rst = 1'b0;

        // Single channel, 20-cycle busy
        $display("[TB] single channel burst");
        busy_len = 20;
        @(posedge aclk); #1 applyStimulus(4'b0010, 4'b0010);
        waitSel(20, gid, gsel);
        checkOutput("single_wsel",  W'(gsel), W'(4'b0010));
        checkOutput("single_waddr", W'(bus.o_ddr_waddr), W'(28'h0000080));
        @(posedge aclk); #1 applyStimulus(4'b0000, 4'b0010);
        cnt_a = 0; cnt_b = 0;
        repeat (60) begin
            @(negedge aclk);
            if (bus.o_ch_wbusy[1]) cnt_a++;
            if ((bus.o_ch_wbusy & 4'b1101) != 0) cnt_b++;
        end
        checkOutput("single_busy_len", W'(cnt_a), W'(20));
        checkOutput("single_busy_other", W'(cnt_b), W'(0));

        // Fairness with all channels eligible
        $display("[TB] round-robin fairness");
        doReset();
        busy_len = 2;
        applyStimulus(4'b1111, 4'b1111);
        for (int g = 0; g < 8; g++) begin
            waitSel(60, gid, gsel);
            checkOutput("fair_grant", W'(gid), W'(g % CH));
        end
        @(posedge aclk); #1 applyStimulus('0, '0);
        repeat (40) @(posedge aclk);

        // Data routing during a ch2 burst
        $display("[TB] data routing");
        doReset();
        busy_len = 10;
        applyStimulus(4'b0100, 4'b0100);
        waitSel(20, gid, gsel);
        @(posedge aclk); #1 applyStimulus(4'b0000, 4'b0100);
        cnt_a = 0;
        repeat (40) begin
            @(negedge aclk);
            if (bus.o_ch_wbusy[2]) begin
                cnt_a++;
                checkOutput("route_rq", W'(bus.o_ch_wdata_rq), W'(bus.i_ddr_wdata_rq ? 4'b0100 : 4'b0000));
                checkOutput("route_wdata", bus.o_ddr_wdata, {16{8'h33}});
            end
        end
        checkOutput("route_busy_len", W'(cnt_a), W'(10));

        // Channel abort after select
        $display("[TB] channel abort");
        applyStimulus(4'b1000, 4'b1000);
        waitSel(20, gid, gsel);
        checkOutput("abort_wsel", W'(gsel), W'(4'b1000));
        @(posedge aclk); #1 applyStimulus(4'b1001, 4'b0001);
        flag = 1'b0;
        gsel = '0;
        for (int c = 0; c < 20 && gsel == '0; c++) begin
            @(negedge aclk);
            if (bus.o_ddr_wrq) flag = 1'b1;
            gsel = bus.o_ch_wsel;
        end
        checkOutput("abort_no_wrq", W'(flag), W'(1'b0));
        checkOutput("abort_next",   W'(gsel), W'(4'b0001));
        @(posedge aclk); #1 applyStimulus('0, '0);
        repeat (30) @(posedge aclk);

        // Watchdog: controller never accepts
        $display("[TB] watchdog");
        ctrl_never = 1'b1;
        #1 applyStimulus(4'b0010, 4'b0010);
        waitSel(20, gid, gsel);
        @(posedge aclk); #1 applyStimulus(4'b0000, 4'b0010);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        repeat (40) begin
            @(negedge aclk);
            if (bus.o_ddr_wrq) cnt_a++;
            if (bus.o_timeout) cnt_b++;
            if (bus.o_ch_wbusy != 0) cnt_c++;
        end
        checkOutput("wd_wrq_cycles", W'(cnt_a), W'(16));
        checkOutput("wd_timeout_pulses", W'(cnt_b), W'(1));
        checkOutput("wd_fake_busy", W'(cnt_c), W'(1));
        ctrl_never = 1'b0;

        // Reset in the middle of a ch1 burst
        $display("[TB] reset mid-burst");
        busy_len = 20;
        @(posedge aclk); #1 applyStimulus(4'b0010, 4'b0010);
        waitSel(20, gid, gsel);
        @(posedge aclk); #1 applyStimulus(4'b0000, 4'b0010);
        flag = 1'b0;
        for (int c = 0; c < 20 && !flag; c++) begin
            @(negedge aclk);
            flag = bus.o_ch_wbusy[1];
        end
        checkOutput("rst_busy_seen", W'(flag), W'(1'b1));
        repeat (3) @(negedge aclk);
        @(posedge aclk); #3 rst = 1'b1;
        #1;
        checkOutput("rst_wsel",  W'(bus.o_ch_wsel),     W'(0));
        checkOutput("rst_rq",    W'(bus.o_ch_wdata_rq), W'(0));
        checkOutput("rst_busy",  W'(bus.o_ch_wbusy),    W'(0));
        checkOutput("rst_wrq",   W'(bus.o_ddr_wrq),     W'(0));
        checkOutput("rst_waddr", W'(bus.o_ddr_waddr),   W'(0));
        checkOutput("rst_wdata", bus.o_ddr_wdata,       W'(0));
        checkOutput("rst_to",    W'(bus.o_timeout),     W'(0));
        repeat (2) @(posedge aclk);
        #1 rst = 1'b0;
        applyStimulus(4'b1111, 4'b1111);
        waitSel(10, gid, gsel);
        checkOutput("rst_first_grant", W'(gsel), W'(4'b0001));
        @(posedge aclk); #1 applyStimulus('0, '0);
        repeat (30) @(posedge aclk);

        // Random traffic
        $display("[TB] random traffic");
        rand_mode = 1'b1;
        acc_max   = 4;
        for (int c = 0; c < 3000; c++) begin
            @(posedge aclk); #1;
            applyStimulus(CH'($urandom), CH'($urandom) | CH'($urandom));
            for (int k = 0; k < CH; k++) bus.i_ch_waddr[k*A +: A] = A'($urandom);
            for (int k = 0; k < CH*W/32; k++) bus.i_ch_wdata[k*32 +: 32] = $urandom;
            if ($urandom_range(0, 199) == 0) ctrl_never = !ctrl_never;
        end
        ctrl_never = 1'b0;
        @(posedge aclk); #1 applyStimulus('0, '0);
        repeat (60) @(posedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
